// File: rtl/victim_write_buffer.sv
// Victim write buffer: FIFO of evicted cache blocks drained to data memory, with write coalescing.
// Defining VWB_READ_FORWARD_EN lets fills hit queued entries instead of waiting for an empty buffer.

module victim_write_buffer #(
    parameter int DEPTH = 4,
    parameter int BLK_W = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      c_addr_i,
    input  logic [BLK_W-1:0] c_data_i,
    input  logic             c_enable_i,
    input  logic             c_write_i,
    output logic             c_ack_o,
    output logic [BLK_W-1:0] c_data_o,
    output logic [31:0]      m_addr_o,
    output logic [BLK_W-1:0] m_data_o,
    output logic             m_enable_o,
    output logic             m_write_o,
    input  logic             m_ack_i,
    input  logic [BLK_W-1:0] m_data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       dbg_state_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ack_q, ack_d;
    logic [BLK_W-1:0] rdata_q, rdata_d;
    logic             full_q, full_d, empty_q, empty_d;

    logic [26:0]      blk_addr_q [DEPTH];
    logic [BLK_W-1:0] blk_data_q [DEPTH];

    logic [26:0]      req_blk;
    logic             addr_offset_unused;
    logic             wr_req, rd_req, wr_accept, push, pop;
    logic             wr_hit;
    logic [PTR_W-1:0] wr_hit_idx, wr_idx;
    logic             rd_start, rd_fwd;
    logic [BLK_W-1:0] fwd_data;

    assign req_blk            = c_addr_i[31:5];
    assign addr_offset_unused = ^c_addr_i[4:0];

    // Requests are ignored while the previous ack is still showing.
    assign wr_req = c_enable_i && c_write_i && !ack_q;
    assign rd_req = c_enable_i && !c_write_i && !ack_q;

    // Coalescing match over valid entries, excluding the head once its drain has started.
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (blk_addr_q[head_q + PTR_W'(i)] == req_blk)
                && !((state_q == ST_DRAIN) && (i == 0))) begin
                wr_hit     = 1'b1;
                wr_hit_idx = head_q + PTR_W'(i);
            end
        end
    end

`ifdef VWB_READ_FORWARD_EN
    logic             fwd_hit;
    logic [PTR_W-1:0] fwd_idx;

    // Scanning oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (blk_addr_q[head_q + PTR_W'(i)] == req_blk)) begin
                fwd_hit = 1'b1;
                fwd_idx = head_q + PTR_W'(i);
            end
        end
    end

    assign rd_start = rd_req && !fwd_hit;
    assign rd_fwd   = rd_req && fwd_hit;
    assign fwd_data = blk_data_q[fwd_idx];
`else
    // Without forwarding a fill must not overtake any queued write-back.
    assign rd_start = rd_req && (count_q == '0);
    assign rd_fwd   = 1'b0;
    assign fwd_data = '0;
`endif

    assign wr_accept = wr_req && (wr_hit || (count_q < FULL_CNT));
    assign push      = wr_accept && !wr_hit;
    assign pop       = (state_q == ST_DRAIN) && m_ack_i;
    assign wr_idx    = wr_hit ? wr_hit_idx : tail_q;

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    state_d = ST_READ;
                end else if (count_q != '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (m_ack_i) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                    rdata_d = m_data_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_accept) begin
            ack_d = 1'b1;
        end
        if (rd_fwd) begin
            ack_d   = 1'b1;
            rdata_d = fwd_data;
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by head/count alone.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            blk_addr_q[wr_idx] <= req_blk;
            blk_data_q[wr_idx] <= c_data_i;
        end
    end

    always_comb begin
        m_enable_o = 1'b0;
        m_write_o  = 1'b0;
        m_addr_o   = '0;
        m_data_o   = '0;
        case (state_q)
            ST_DRAIN: begin
                m_enable_o = 1'b1;
                m_write_o  = 1'b1;
                m_addr_o   = {blk_addr_q[head_q], 5'b0};
                m_data_o   = blk_data_q[head_q];
            end
            ST_READ: begin
                m_enable_o = 1'b1;
                m_addr_o   = {req_blk, 5'b0};
            end
            default: ;
        endcase
    end

    assign c_ack_o     = ack_q;
    assign c_data_o    = rdata_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_victim_write_buffer.sv
// Directed bench for victim_write_buffer: write-back ordering, full stall, coalescing, fills, reset.
// A small memory model answers m_enable_o after a programmable latency and logs every transaction.

module tb_victim_write_buffer;
    localparam int DEPTH = 4;
    localparam int BLK_W = 256;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [31:0]      c_addr_i;
    logic [BLK_W-1:0] c_data_i;
    logic             c_enable_i;
    logic             c_write_i;
    logic             c_ack_o;
    logic [BLK_W-1:0] c_data_o;
    logic [31:0]      m_addr_o;
    logic [BLK_W-1:0] m_data_o;
    logic             m_enable_o;
    logic             m_write_o;
    logic             m_ack_i;
    logic [BLK_W-1:0] m_data_i;
    logic             full_o;
    logic             empty_o;
    logic [1:0]       dbg_state_o;

    int total = 0;
    int bad = 0;

    logic [BLK_W-1:0] mem [0:255];
    logic [31:0]      wr_addr_log [$];
    logic [BLK_W-1:0] wr_data_log [$];
    logic [31:0]      rd_addr_log [$];
    int               mem_lat = 10;
    bit               mem_hold = 1'b0;
    int               wait_cnt = 0;

    always #5 clk_i = ~clk_i;

    victim_write_buffer #(.DEPTH(DEPTH), .BLK_W(BLK_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_addr_i(c_addr_i), .c_data_i(c_data_i), .c_enable_i(c_enable_i), .c_write_i(c_write_i),
        .c_ack_o(c_ack_o), .c_data_o(c_data_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_enable_o(m_enable_o), .m_write_o(m_write_o),
        .m_ack_i(m_ack_i), .m_data_i(m_data_i),
        .full_o(full_o), .empty_o(empty_o), .dbg_state_o(dbg_state_o)
    );

    function automatic logic [BLK_W-1:0] pat(input logic [31:0] v);
        return {8{v}};
    endfunction

    task automatic chk_w(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Memory model: acks after mem_lat cycles of m_enable_o, acting just after the rising edge.
    initial begin
        m_ack_i  = 1'b0;
        m_data_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = pat(32'hA500_0000 + 32'(i));
        forever begin
            @(posedge clk_i);
            #1;
            m_ack_i = 1'b0;
            if (rst_i && m_enable_o && !mem_hold) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    wait_cnt = 0;
                    m_ack_i  = 1'b1;
                    if (m_write_o) begin
                        wr_addr_log.push_back(m_addr_o);
                        wr_data_log.push_back(m_data_o);
                        mem[m_addr_o[12:5]] = m_data_o;
                    end else begin
                        rd_addr_log.push_back(m_addr_o);
                        m_data_i = mem[m_addr_o[12:5]];
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Holds the request until c_ack_o, then leaves one idle cycle; n = cycles to ack.
    task automatic cache_write(input logic [31:0] a, input logic [BLK_W-1:0] d, output int n);
        c_addr_i   = a;
        c_data_i   = d;
        c_write_i  = 1'b1;
        c_enable_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!c_ack_o && n < 200);
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;
        step(1);
    endtask

    task automatic cache_read(input logic [31:0] a, output logic [BLK_W-1:0] d, output int n);
        c_addr_i   = a;
        c_write_i  = 1'b0;
        c_enable_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!c_ack_o && n < 200);
        d = c_data_o;
        c_enable_i = 1'b0;
        step(1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!(empty_o && !m_enable_o) && n < 400) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk_i({pfx, "_c_ack"}, int'(c_ack_o), 0);
        chk_w({pfx, "_c_data"}, c_data_o, '0);
        chk_i({pfx, "_m_enable"}, int'(m_enable_o), 0);
        chk_i({pfx, "_m_write"}, int'(m_write_o), 0);
        chk_i({pfx, "_m_addr"}, int'(m_addr_o), 0);
        chk_w({pfx, "_m_data"}, m_data_o, '0);
        chk_i({pfx, "_full"}, int'(full_o), 0);
        chk_i({pfx, "_empty"}, int'(empty_o), 1);
        chk_i({pfx, "_state"}, int'(dbg_state_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        logic [BLK_W-1:0] d;

        rst_i      = 1'b1;
        c_addr_i   = '0;
        c_data_i   = '0;
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;

        // Reset values
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("rst");
        step(2);
        rst_i = 1'b1;
        step(1);

        // Three write-backs drained in order with a 10-cycle memory
        mem_lat = 10;
        cache_write(32'h0000_0000, pat(32'h1111_0000), n);
        chk_i("s1_ack_lat_0", n, 1);
        cache_write(32'h0000_0200, pat(32'h1111_0001), n);
        chk_i("s1_ack_lat_1", n, 1);
        cache_write(32'h0000_0400, pat(32'h1111_0002), n);
        chk_i("s1_ack_lat_2", n, 1);
        wait_idle(n);
        chk_i("s1_drain_done", int'(n < 400), 1);
        chk_i("s1_wr_count", wr_addr_log.size(), 3);
        chk_i("s1_wr_addr_0", int'(wr_addr_log[0]), 32'h000);
        chk_i("s1_wr_addr_1", int'(wr_addr_log[1]), 32'h200);
        chk_i("s1_wr_addr_2", int'(wr_addr_log[2]), 32'h400);
        chk_w("s1_wr_data_2", wr_data_log[2], pat(32'h1111_0002));
        chk_i("s1_empty", int'(empty_o), 1);

        // Full buffer withholds the fifth ack until the first pop
        clear_logs();
        mem_hold = 1'b1;
        mem_lat  = 2;
        for (int i = 0; i < 4; i++) begin
            cache_write(32'h0000_1000 + 32'(i) * 32'h20, pat(32'h2222_0000 + 32'(i)), n);
            chk_i("s2_ack_lat", n, 1);
        end
        chk_i("s2_full", int'(full_o), 1);
        c_addr_i   = 32'h0000_1080;
        c_data_i   = pat(32'h2222_0004);
        c_write_i  = 1'b1;
        c_enable_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (c_ack_o) acks++;
        end
        chk_i("s2_fifth_withheld", acks, 0);
        mem_hold = 1'b0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!c_ack_o && n < 50);
        chk_i("s2_fifth_lat_after_release", n, 4);
        chk_i("s2_pops_before_fifth", wr_addr_log.size(), 1);
        c_enable_i = 1'b0;
        c_write_i  = 1'b0;
        step(1);
        wait_idle(n);
        chk_i("s2_drain_done", int'(n < 400), 1);
        chk_i("s2_wr_count", wr_addr_log.size(), 5);
        chk_i("s2_wr_addr_first", int'(wr_addr_log[0]), 32'h1000);
        chk_i("s2_wr_addr_last", int'(wr_addr_log[4]), 32'h1080);
        chk_w("s2_wr_data_last", wr_data_log[4], pat(32'h2222_0004));

        // Coalescing into a queued, non-draining entry
        clear_logs();
        mem_hold = 1'b1;
        cache_write(32'h0000_0600, pat(32'h3333_0001), n);
        cache_write(32'h0000_0200, pat(32'h3333_000A), n);
        cache_write(32'h0000_0200, pat(32'h3333_000B), n);
        chk_i("s3_coalesce_ack_lat", n, 1);
        cache_write(32'h0000_0800, pat(32'h3333_0002), n);
        chk_i("s3_not_full", int'(full_o), 0);
        mem_hold = 1'b0;
        wait_idle(n);
        chk_i("s3_wr_count", wr_addr_log.size(), 3);
        chk_i("s3_wr_addr_0", int'(wr_addr_log[0]), 32'h600);
        chk_i("s3_wr_addr_1", int'(wr_addr_log[1]), 32'h200);
        chk_w("s3_wr_data_1", wr_data_log[1], pat(32'h3333_000B));
        chk_i("s3_wr_addr_2", int'(wr_addr_log[2]), 32'h800);

        // Read of a block just written back
        clear_logs();
        mem_lat = 3;
        cache_write(32'h0000_0400, pat(32'h4444_000C), n);
        cache_read(32'h0000_0404, d, n);
        chk_w("s4_read_data", d, pat(32'h4444_000C));
`ifdef VWB_READ_FORWARD_EN
        chk_i("s4_fwd_lat", n, 1);
        chk_i("s4_no_mem_read", rd_addr_log.size(), 0);
`else
        chk_i("s4_mem_read_count", rd_addr_log.size(), 1);
        chk_i("s4_mem_read_addr", int'(rd_addr_log[0]), 32'h400);
        chk_i("s4_write_first", wr_addr_log.size(), 1);
`endif
        wait_idle(n);

        // Read miss arriving during an active drain
        clear_logs();
        mem_lat = 6;
        cache_write(32'h0000_0800, pat(32'h5555_0000), n);
        n = 0;
        while (!m_enable_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk_i("s5_drain_active", int'(m_write_o), 1);
        cache_read(32'h0000_0040, d, n);
        chk_w("s5_read_data", d, pat(32'hA500_0002));
        chk_i("s5_read_addr", int'(rd_addr_log[0]), 32'h040);
        chk_i("s5_drain_before_read", wr_addr_log.size(), 1);
        chk_i("s5_drain_addr", int'(wr_addr_log[0]), 32'h800);
        wait_idle(n);

        // Reset in the middle of a drain
        clear_logs();
        mem_hold = 1'b1;
        cache_write(32'h0000_0C00, pat(32'h6666_0001), n);
        cache_write(32'h0000_0C20, pat(32'h6666_0002), n);
        chk_i("s6_draining", int'(m_enable_o), 1);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("s6_rst");
        step(2);
        rst_i    = 1'b1;
        mem_hold = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (m_enable_o) acks++;
        end
        chk_i("s6_no_mem_req", acks, 0);
        chk_i("s6_no_mem_write", wr_addr_log.size(), 0);
        chk_i("s6_empty", int'(empty_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
